// File: rtl/fir_pkg.sv
// Shared widths and fixed-point types for the FIR accelerator.
package fir_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 8;
  localparam int Q_FORMAT   = 8;
  localparam int SCALE      = 2 ** Q_FORMAT;
  localparam int ADDR_WIDTH = 3;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + 3;
  localparam int CNT_WIDTH  = $clog2(NUM_REGS + 1);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [DATA_WIDTH-1:0] coeff_t;
endpackage

// File: rtl/fir_coeff_regfile.sv
// Coefficient bank: one write port, all slots readable in parallel.
// No reset on purpose: contents survive both reset and clear.
module fir_coeff_regfile
  import fir_pkg::*;
(
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  coeff_t                wdata_i,
  output coeff_t                coeffs_o [NUM_REGS]
);

  coeff_t coeffs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      coeffs_q[addr_i] <= wdata_i;
    end
  end

  assign coeffs_o = coeffs_q;

endmodule

// File: rtl/fir_top.sv
// FIR accelerator: delay line, signed MAC of taps against the coefficient bank,
// Q-format rescale and saturation; result registered one cycle after a sample is accepted.
module fir_top
  import fir_pkg::*;
(
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         clrC,
  input  logic                         coeffWriteEn,
  input  logic [ADDR_WIDTH-1:0]        coeffAddress,
  input  logic signed [DATA_WIDTH-1:0] coeffsIn,
  input  logic                         accelerateEn,
  input  logic [DATA_WIDTH-1:0]        rawSensorVal,
  output logic signed [DATA_WIDTH-1:0] macResult,
  output logic                         resultIsValid
);

  localparam sample_t SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  coeff_t                 coeffs [NUM_REGS];
  sample_t                taps_q [NUM_REGS];
  sample_t                taps_d [NUM_REGS];
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   acc_en_q, acc_en_d;
  sample_t                mac_q, mac_d;
  logic                   vld_q, vld_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic signed [ACC_WIDTH-1:0]    acc_shift;
  logic [ACC_WIDTH-DATA_WIDTH:0]  acc_hi;
  sample_t                        sat_res;

  fir_coeff_regfile u_coeffs (
    .clk      (clk),
    .we_i     (coeffWriteEn),
    .addr_i   (coeffAddress),
    .wdata_i  (coeffsIn),
    .coeffs_o (coeffs)
  );

  always_comb begin
    prod    = '0;
    acc_sum = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      prod    = (2*DATA_WIDTH)'(taps_q[i]) * (2*DATA_WIDTH)'(coeffs[i]);
      acc_sum = acc_sum + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    end
    acc_shift = acc_sum >>> Q_FORMAT;
    // In range only when every bit above the result's sign bit matches it.
    acc_hi = acc_shift[ACC_WIDTH-1:DATA_WIDTH-1];
    if ((&acc_hi) || !(|acc_hi)) begin
      sat_res = acc_shift[DATA_WIDTH-1:0];
    end else begin
      sat_res = acc_shift[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    taps_d   = taps_q;
    cnt_d    = cnt_q;
    acc_en_d = accelerateEn;
    mac_d    = mac_q;
    vld_d    = 1'b0;
    if (accelerateEn) begin
      taps_d[0] = sample_t'(rawSensorVal);
      for (int i = 1; i < NUM_REGS; i++) begin
        taps_d[i] = taps_q[i-1];
      end
      if (cnt_q != CNT_WIDTH'(NUM_REGS)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
    // Result follows the accepted sample by one edge, even if the enable has since dropped.
    if (acc_en_q) begin
      mac_d = sat_res;
      vld_d = (cnt_q == CNT_WIDTH'(NUM_REGS));
    end
  end

  always_ff @(posedge clk) begin
    if (rstN || clrC) begin
      taps_q   <= '{default: '0};
      cnt_q    <= '0;
      acc_en_q <= 1'b0;
      mac_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      taps_q   <= taps_d;
      cnt_q    <= cnt_d;
      acc_en_q <= acc_en_d;
      mac_q    <= mac_d;
      vld_q    <= vld_d;
    end
  end

  assign macResult     = mac_q;
  assign resultIsValid = vld_q;

endmodule

// File: tb/tb_fir_top.sv
// Directed and randomized checks of fir_top against a window/queue reference model.
module tb_fir_top;
  import fir_pkg::*;

  logic               clk = 1'b0;
  logic               rstN, clrC, coeffWriteEn, accelerateEn;
  logic [2:0]         coeffAddress;
  logic signed [15:0] coeffsIn;
  logic [15:0]        rawSensorVal;
  logic signed [15:0] macResult;
  logic               resultIsValid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: accepted samples since last clear (newest first), coefficient values.
  int                 win[$];
  int                 coef[8];
  logic signed [15:0] exp_mac;
  logic               exp_vld;
  bit                 pend;

  always #5 clk = ~clk;

  fir_top dut (
    .clk           (clk),
    .rstN          (rstN),
    .clrC          (clrC),
    .coeffWriteEn  (coeffWriteEn),
    .coeffAddress  (coeffAddress),
    .coeffsIn      (coeffsIn),
    .accelerateEn  (accelerateEn),
    .rawSensorVal  (rawSensorVal),
    .macResult     (macResult),
    .resultIsValid (resultIsValid)
  );

  function automatic logic signed [15:0] ref_mac();
    longint s = 0;
    for (int i = 0; i < win.size(); i++) s += longint'(win[i]) * longint'(coef[i]);
    s = s >>> Q_FORMAT;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic check(input string tag);
    n_tests++;
    assert (macResult === exp_mac) else begin
      n_fail++;
      $error("FAIL %s macResult got %0d want %0d", tag, macResult, exp_mac);
    end
    n_tests++;
    assert (resultIsValid === exp_vld) else begin
      n_fail++;
      $error("FAIL %s resultIsValid got %0b want %0b", tag, resultIsValid, exp_vld);
    end
  endtask

  task automatic check_const(input string tag, input logic signed [15:0] want, input logic want_vld);
    n_tests++;
    assert (macResult === want && resultIsValid === want_vld) else begin
      n_fail++;
      $error("FAIL %s got %0d/%0b want %0d/%0b", tag, macResult, resultIsValid, want, want_vld);
    end
  endtask

  task automatic step(input bit rst, input bit clr, input bit acc, input logic [15:0] samp,
                      input bit we, input logic [2:0] addr, input logic [15:0] cval,
                      input string tag);
    @(negedge clk);
    rstN = rst; clrC = clr; accelerateEn = acc; rawSensorVal = samp;
    coeffWriteEn = we; coeffAddress = addr; coeffsIn = cval;
    @(posedge clk);
    if (rst || clr) begin
      win.delete();
      exp_mac = '0;
      exp_vld = 1'b0;
      pend    = 1'b0;
    end else begin
      if (pend) begin
        exp_mac = ref_mac();
        exp_vld = (win.size() == NUM_REGS);
      end else begin
        exp_vld = 1'b0;
      end
      if (acc) begin
        win.push_front(int'($signed(samp)));
        if (win.size() > NUM_REGS) void'(win.pop_back());
      end
      pend = acc;
    end
    if (we) coef[addr] = int'($signed(cval));
    #1;
    check(tag);
  endtask

  task automatic feed(input logic [15:0] samp, input string tag);
    step(0, 0, 1, samp, 0, 3'd0, 16'd0, tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 16'd0, 0, 3'd0, 16'd0, tag);
  endtask

  task automatic fill_coef(input logic [15:0] cval);
    for (int a = 0; a < 8; a++) step(0, 0, 0, 16'd0, 1, 3'(a), cval, "coef_wr");
  endtask

  initial begin
    rstN = 1'b0; clrC = 1'b0; coeffWriteEn = 1'b0; accelerateEn = 1'b0;
    coeffAddress = '0; coeffsIn = '0; rawSensorVal = '0;
    exp_mac = '0; exp_vld = 1'b0; pend = 1'b0;
    for (int i = 0; i < 8; i++) coef[i] = 0;

    step(1, 0, 0, 16'd0, 0, 3'd0, 16'd0, "reset");
    check_const("reset_const", 16'sd0, 1'b0);

    fill_coef(16'h0033);
    for (int i = 0; i < 8; i++) feed(16'h0300, "const3");
    idle("const3_out");
    check_const("const3_1224", 16'sd1224, 1'b1);

    for (int i = 1; i <= 5; i++) feed(16'(i * SCALE), "ramp");
    for (int i = 0; i < 6; i++) feed(16'($urandom_range(0, 16'hFFFF)), "rand_a");

    for (int i = 0; i < 3; i++) idle("gap");
    for (int i = 0; i < 3; i++) feed(16'($urandom_range(0, 16'hFFFF)), "resume");

    step(1, 0, 1, 16'h1234, 0, 3'd0, 16'd0, "mid_rst");
    check_const("mid_rst_zero", 16'sd0, 1'b0);
    for (int i = 0; i < 9; i++) feed(16'($urandom_range(0, 16'hFFFF)), "refill_rst");

    step(0, 1, 1, 16'h0100, 1, 3'd5, 16'h0100, "clr_wr");
    check_const("clr_zero", 16'sd0, 1'b0);
    for (int i = 0; i < 8; i++) feed(16'h0100, "refill_clr");
    idle("refill_clr_out");
    // Seven taps of 0x33 plus the 0x100 written during clear, all at 1.0.
    check_const("clr_wr_landed", 16'sd613, 1'b1);

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 25) == 0),
           ($urandom_range(0, 3) != 0), 16'($urandom_range(0, 16'hFFFF)),
           ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
           16'($urandom_range(0, 16'hFFFF)), "random");
    end

    fill_coef(16'h7FFF);
    for (int i = 0; i < 8; i++) feed(16'h7FFF, "sat_pos");
    idle("sat_pos_out");
    check_const("sat_pos_7fff", 16'sh7FFF, 1'b1);
    for (int i = 0; i < 8; i++) feed(16'h8001, "sat_neg");
    idle("sat_neg_out");
    check_const("sat_neg_8000", -16'sd32768, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_top.md
# fir_top

Top level of the fixed-point FIR accelerator. It holds a programmable bank of signed Q-format coefficients and a delay line of raw sensor samples. Each enabled cycle it shifts in one sample and produces the signed multiply-accumulate of the delay line against the coefficients. It sits between the sensor interface and downstream consumers of filtered data.

## Interface
- DATA_WIDTH, 16: width of samples, coefficients and result (two's complement fixed point).
- NUM_REGS, 8: number of taps; also coefficient bank depth (addressed by 3 bits).
- Q_FORMAT, 8: fractional bits; SCALE = 2**Q_FORMAT (1.0 = 256).
- clk  in  1: single clock; all state updates on rising edge.
- rstN  in  1: reset, synchronous, active-high (port name kept per codebase).
- clrC  in  1: synchronous clear of delay line, fill count and result; coefficients kept.
- coeffWriteEn  in  1: write coeffsIn into coefficient slot coeffAddress this edge.
- coeffAddress  in  3: coefficient slot index 0..7.
- coeffsIn  in  DATA_WIDTH signed: coefficient value, Q_FORMAT fractional bits.
- accelerateEn  in  1: accept rawSensorVal and advance the filter this edge.
- rawSensorVal  in  DATA_WIDTH: sample, treated as signed Q_FORMAT.
- macResult  out  DATA_WIDTH signed: filter output, Q_FORMAT fractional bits.
- resultIsValid  out  1: macResult holds a full-window result.

## Operation
- Coefficient bank: NUM_REGS signed registers. Write on edge with coeffWriteEn=1 at coeffAddress. Not cleared by rstN or clrC; power-up contents are don't-care until written.
- Delay line: tap[0] newest. On edge with accelerateEn=1: tap[0] <= rawSensorVal, tap[i] <= tap[i-1].
- Arithmetic:
  - Full-precision signed products tap[i]*coeff[i] (2*DATA_WIDTH bits).
  - Summed in an accumulator of 2*DATA_WIDTH+3 bits.
  - Arithmetic shift right by Q_FORMAT (truncate toward -inf).
  - Saturate to signed DATA_WIDTH range.
- Fill counter: counts accepted samples, saturating at NUM_REGS. resultIsValid requires count = NUM_REGS.
- Priority per edge: rstN > clrC > normal operation. Coefficient writes proceed during clrC and alongside accelerateEn.
- rstN=1: taps, fill count, macResult (0) and resultIsValid (0) cleared. clrC=1: identical effect on those registers.

## Timing
- Reset values: macResult = 0, resultIsValid = 0.
- Edge k accepts a sample (accelerateEn=1). Edge k+1 registers macResult from the window containing that sample, using coefficients as present at edge k+1. Latency is 1 cycle.
- resultIsValid is registered alongside macResult. It is 1 at edge k+1 only if accelerateEn was 1 at edge k and the fill count reached NUM_REGS.
- accelerateEn=0: taps and macResult hold; resultIsValid drops to 0 at the next edge.
- A coefficient written at edge k affects results registered at edge k+1 onward.
- Reset or clear mid-stream: the next valid result comes NUM_REGS accepted samples later. No partial-window valid.

## Structure
- Package fir_pkg: DATA_WIDTH, NUM_REGS, Q_FORMAT, SCALE, ADDR_WIDTH (3), ACC_WIDTH, and a signed sample_t/coeff_t typedef.
- Sub-module fir_coeff_regfile: coefficient bank with write port and parallel read of all slots.
- The delay line, MAC tree, saturation and valid logic stay in fir_top.

## Test plan
- Write 0x0033 (0.2 ≈ 51/256) to all 8 slots, then feed 8 samples of 0x0300 (3.0). Required response:
  - macResult = (8*768*51)>>8 = 1224 (≈4.78), valid=1 one cycle after the 8th sample.
  - valid=0 before that.
- Same coefficients, ramp samples 1.0..5.0. Each valid result must match the golden model sum(tap*coeff)>>8 exactly.
- Drop accelerateEn for 3 cycles mid-stream. Required response:
  - macResult holds and valid=0 during the gap.
  - On resume, the window continues from the held taps and valid returns after the first accepted sample.
- Pulse rstN for one cycle mid-stream. Required response:
  - macResult=0, valid=0 next edge.
  - Coefficients retained.
  - valid reasserts only after 8 new samples.
- Assert clrC mid-stream: same as the rstN scenario. Also assert clrC together with a coefficient write and check the coefficient write still lands.
- Coefficients 0x7FFF on all taps with samples 0x7FFF: macResult saturates to 0x7FFF. Negated samples: macResult saturates to 0x8000.
